// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// operand width and the bit-counter sizing helper.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must be able to hold WIDTH itself so it never wraps mid-operation.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the serial adder. Optional ovf output is present
// only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, op_a, op_b, cin,
                    input  busy, done, sum, cout, ovf);
    modport slave  (input  start, op_a, op_b, cin,
                    output busy, done, sum, cout, ovf);
`else
    modport master (output start, op_a, op_b, cin,
                    input  busy, done, sum, cout);
    modport slave  (input  start, op_a, op_b, cin,
                    output busy, done, sum, cout);
`endif

endinterface

// File: rtl/fa_cell.sv
// One-bit full adder used as the serial adder's per-cycle bit slice.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: captures A, B, cin on start, adds one bit per cycle LSB
// first, then presents sum/cout with a one-cycle done. Optional ovf output
// is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH must be in 2..32");
    end

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             s_bit;
    logic             c_bit;
    logic             last_bit;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign acc_d    = {s_bit, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        carry_q <= bus.cin;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    carry_q <= c_bit;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        // Result becomes visible only here, never mid-shift.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= acc_d;
                        cout_q  <= c_bit;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= carry_q ^ c_bit;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand shifters and partial-sum register carry no reset: they are
    // fully reloaded before any result is taken from them.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start) begin
            a_q <= bus.op_a;
            b_q <= bus.op_b;
        end else if (state_q == SHIFT) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            acc_q <= acc_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to add; sampled only in IDLE.
REQ-005 The block SHALL have port op_a, input, WIDTH bits: addend A, captured with start.
REQ-006 The block SHALL have port op_b, input, WIDTH bits: addend B, captured with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result, held until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1 bit: final carry, held with sum.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT and DONE; transitions: IDLE->SHIFT on start; SHIFT->DONE after WIDTH bit cycles; DONE->IDLE unconditionally.
REQ-013 When start is high in IDLE at edge k, the block SHALL capture op_a, op_b and cin, load the carry flop with cin, and clear the bit counter.
REQ-014 In each SHIFT cycle, the block SHALL add operand bit i of A, bit i of B and the carry flop, LSB first; it SHALL shift the sum bit into the result register MSB end and store the carry-out in the carry flop.
REQ-015 busy SHALL be high for exactly WIDTH cycles, edges k+1..k+WIDTH.
REQ-016 done SHALL be high for exactly one cycle, at k+WIDTH+1; sum and cout SHALL equal (op_a+op_b+cin) mod 2^WIDTH and its carry in that cycle.
REQ-017 The block SHALL ignore start while in SHIFT or DONE; captured operands and results SHALL be unaffected.
REQ-018 The block SHALL change sum and cout only at done; intermediate shift contents SHALL NOT be visible on sum.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-020 While rst is high, state SHALL be IDLE, and busy, done, sum, cout, the carry flop and the counter SHALL all be 0.
REQ-021 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; rst SHALL take priority over start.

Configuration
REQ-022 With macro SERIAL_ADD_OVF_EN defined, the block SHALL add output ovf, 1 bit, equal to the two's-complement signed overflow (carry into MSB XOR carry out of MSB); ovf SHALL update and hold like cout and reset to 0.
REQ-023 Without SERIAL_ADD_OVF_EN, the block SHALL have no ovf port and no related logic.

Structure
REQ-024 A shared adder package SHALL hold the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default width constant.
REQ-025 The per-bit add SHALL be a sub-module fa_cell (a, b, ci -> s, co), purely combinational, instantiated once.

Verification (WIDTH=8)
REQ-026 The bench SHALL check: op_a=0x0F, op_b=0x01, cin=0, start at edge 0 -> busy at edges 1..8, done at edge 9, sum=0x10, cout=0.
REQ-027 The bench SHALL check: op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1; with cin=1 -> sum=0x01, cout=1.
REQ-028 The bench SHALL check: start re-asserted with 0xAA/0x55 during SHIFT of 0x03+0x04 -> single done, sum=0x07; the second request is ignored.
REQ-029 The bench SHALL check: rst asserted at edge 4 of an operation -> no done pulse, all outputs 0 the next cycle, and a fresh start afterwards completes normally.
REQ-030 With SERIAL_ADD_OVF_EN defined, the bench SHALL check: 0x7F+0x01 -> sum=0x80, ovf=1, cout=0; 0x80+0x80 -> sum=0x00, ovf=1, cout=1; 0x10+0x20 -> ovf=0.
REQ-031 The bench SHALL run 1000 random back-to-back operations comparing against a reference sum, with start held high continuously, and check that every result and done timing matches REQ-016.
